// File: rtl/relu_burst_arbiter.sv
// Round-robin burst arbiter sharing one serial ReLU; each result appears RELU_LAT cycles after its beat is accepted.
// Beats may stall via in_valid; in_ready is high only in STREAM; there is no output backpressure.
module relu_burst_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int BURST_LEN  = 16,
    parameter int RELU_LAT   = 1,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int IDX_W     = $clog2(BURST_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         relu_in_data,
    output logic                          relu_in_valid,
    input  logic [DATA_WIDTH-1:0]         relu_out_data,
    input  logic                          relu_out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic [ID_W-1:0]               out_id,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last,
    output logic                          burst_done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             vld;
    } tag_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, win_id, win_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [NUM_REQ-1:0] req_rot;
    logic               accept, beat_last;
    tag_t               tag_in, tag_head;
    tag_t               tag_pipe [RELU_LAT];

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    assign req_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        win_nxt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) win_nxt = ID_W'((int'(ptr) + i) % NUM_REQ);
        end
    end

    assign accept    = relu_in_valid;
    assign beat_last = (cnt == IDX_W'(BURST_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = STREAM;
            STREAM:  if (accept && beat_last) state_nxt = DRAIN;
            DRAIN:   if (tag_head.vld && tag_head.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = '0;
        relu_in_valid = 1'b0;
        relu_in_data  = '0;
        if (state == STREAM) begin
            in_ready      = gnt;
            relu_in_valid = |(in_valid & gnt);
            relu_in_data  = in_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= '0;
            win_id <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt    <= NUM_REQ'(1) << win_nxt;
                    win_id <= win_nxt;
                    cnt    <= '0;
                end
                STREAM: if (accept) cnt <= cnt + 1'b1;
                DRAIN: if (state_nxt == IDLE) begin
                    gnt <= '0;
                    ptr <= ID_W'((int'(win_id) + 1) % NUM_REQ);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tag_in = '0;
        if (accept) begin
            tag_in.id   = win_id;
            tag_in.idx  = cnt;
            tag_in.last = beat_last;
            tag_in.vld  = 1'b1;
        end
    end

    // Tag pipe mirrors the ReLU latency so the head lines up with relu_out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RELU_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RELU_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_head   = tag_pipe[RELU_LAT-1];
    assign out_valid  = relu_out_valid & tag_head.vld;
    assign out_data   = out_valid ? relu_out_data : '0;
    assign out_id     = tag_head.id;
    assign out_idx    = tag_head.idx;
    assign out_last   = tag_head.last;
    assign burst_done = out_valid & tag_head.last;

endmodule

// File: tb/tb_relu_burst_arbiter.sv
// Directed bench for relu_burst_arbiter with a 1-cycle registered ReLU model.
module tb_relu_burst_arbiter;
    localparam int DW = 16, NR = 2, BL = 4, RL = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req, gnt, in_valid, in_ready;
    logic [NR*DW-1:0] in_data;
    logic [DW-1:0]   relu_in_data, relu_out_data, out_data;
    logic            relu_in_valid, relu_out_valid, out_valid, out_last, burst_done;
    logic [0:0]      out_id;
    logic [1:0]      out_idx;
    int              checks = 0;
    int              errors = 0;

    relu_burst_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL), .RELU_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .relu_in_data(relu_in_data), .relu_in_valid(relu_in_valid),
        .relu_out_data(relu_out_data), .relu_out_valid(relu_out_valid),
        .out_data(out_data), .out_valid(out_valid), .out_id(out_id),
        .out_idx(out_idx), .out_last(out_last), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    // Shared ReLU unit: one registered stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            relu_out_valid <= 1'b0;
            relu_out_data  <= '0;
        end else begin
            relu_out_valid <= relu_in_valid;
            relu_out_data  <= relu_in_data[DW-1] ? '0 : relu_in_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle with req already set. d/e pack beat k at bits [k*16 +: 16].
    task automatic run_burst(input int who, input logic [63:0] d, input logic [63:0] e,
                             input logic [1:0] req_during, input int gap, input int exp_cyc);
        logic [1:0] oh;
        int         k, stall, acc_prev, ncyc;
        logic       seen_last;
        oh = 2'b01 << who;
        k = 0; stall = gap; acc_prev = -1; ncyc = 0; seen_last = 1'b0;
        #2;
        chk("idle_gnt", gnt, 0);
        chk("idle_out_valid", out_valid, 0);
        step();
        req = req_during;
        while (!seen_last && ncyc < 40) begin
            in_valid = '0;
            if (k < 4 && !(k == 2 && stall > 0)) begin
                in_valid[who] = 1'b1;
                in_data[who*16 +: 16] = d[k*16 +: 16];
            end
            #2;
            chk("gnt", gnt, oh);
            chk("in_ready", in_ready, (k < 4) ? oh : 2'b00);
            chk("out_valid", out_valid, acc_prev >= 0);
            if (acc_prev >= 0) begin
                chk("out_data", out_data, e[acc_prev*16 +: 16]);
                chk("out_id", out_id, who);
                chk("out_idx", out_idx, acc_prev);
                chk("out_last", out_last, acc_prev == 3);
                chk("burst_done", burst_done, acc_prev == 3);
                seen_last = (acc_prev == 3);
            end
            chk("relu_in_valid", relu_in_valid, in_valid[who]);
            acc_prev = -1;
            if (in_valid[who]) begin
                chk("relu_in_data", relu_in_data, d[k*16 +: 16]);
                acc_prev = k;
                k++;
            end else if (k == 2) begin
                stall--;
            end
            step();
            ncyc++;
        end
        in_valid = '0;
        chk("burst_end", seen_last, 1);
        chk("burst_cycles", ncyc, exp_cyc);
    endtask

    initial begin
        req = '0; in_valid = '0; in_data = '0;
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_relu_in_valid", relu_in_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_burst_done", burst_done, 0);
        step(); step();
        rst = 1'b1;

        // Single burst from requester 0; req dropped mid-burst, burst still completes.
        req = 2'b01;
        run_burst(0, {16'hFFFF, 16'h0000, 16'h0005, 16'hFFFD},
                     {16'h0000, 16'h0000, 16'h0005, 16'h0000}, 2'b00, 0, 5);

        // ptr is now 1: both requesting -> order 1, 0, 1, 0.
        req = 2'b11;
        run_burst(1, {16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000},
                     {16'h0000, 16'h0001, 16'h7FFF, 16'h0000}, 2'b11, 0, 5);
        run_burst(0, {16'hFFFE, 16'h1234, 16'h8001, 16'h0010},
                     {16'h0000, 16'h1234, 16'h0000, 16'h0010}, 2'b11, 0, 5);
        run_burst(1, {16'h7000, 16'h0042, 16'hF000, 16'h0100},
                     {16'h7000, 16'h0042, 16'h0000, 16'h0100}, 2'b11, 3, 8);
        run_burst(0, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                     {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 2'b11, 0, 5);

        // Reset in the middle of a burst from requester 0.
        req = 2'b01;
        step();
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_valid = 2'b01;
            in_data[15:0] = 16'h0005;
            step();
        end
        #2;
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_out_idx", out_idx, 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_burst_done", burst_done, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_relu_in_valid", relu_in_valid, 0);
        in_valid = '0;
        req = 2'b10;
        step(); step();
        rst = 1'b1;
        run_burst(1, {16'h8000, 16'h0001, 16'hFFFF, 16'h0033},
                     {16'h0000, 16'h0001, 16'h0000, 16'h0033}, 2'b10, 0, 5);

        // Contention straight out of reset: requester 0 first, then 1.
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
        req = 2'b11;
        run_burst(0, {16'h0007, 16'hFF00, 16'h00FF, 16'h9999},
                     {16'h0007, 16'h0000, 16'h00FF, 16'h0000}, 2'b11, 0, 5);
        run_burst(1, {16'h0001, 16'h7FFE, 16'h8000, 16'h0002},
                     {16'h0001, 16'h7FFE, 16'h0000, 16'h0002}, 2'b00, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_burst_arbiter.md
# relu_burst_arbiter

Round-robin burst arbiter and sequencer that shares one serial ReLU unit (1-cycle registered latency, no backpressure) among several SE-layer producers. It grants one requester at a time for a fixed-length burst and streams that requester's beats into the ReLU. Each ReLU result is tagged with requester ID, beat index and last flag, and completion is signalled per burst. It sits between the SE squeeze/FC producers and the shared activation unit.

## Interface

- DATA_WIDTH, 16, activation word width (signed in, unsigned out)
- NUM_REQ, 2, number of requesters (2..8)
- BURST_LEN, 16, beats per granted burst (2..256)
- RELU_LAT, 1, ReLU latency in cycles (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester burst request, level
- gnt  output  NUM_REQ  one-hot grant, held for the whole burst
- in_data  input  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_REQ  per-requester beat valid
- in_ready  output  NUM_REQ  per-requester beat ready; equals gnt while in STREAM, otherwise 0
- relu_in_data  output  DATA_WIDTH  to ReLU in_data
- relu_in_valid  output  1  to ReLU in_valid
- relu_out_data  input  DATA_WIDTH  from ReLU out_data
- relu_out_valid  input  1  from ReLU out_valid
- out_data  output  DATA_WIDTH  activated result
- out_valid  output  1  result valid
- out_id  output  $clog2(NUM_REQ)  owner of the result
- out_idx  output  $clog2(BURST_LEN)  beat index within the burst
- out_last  output  1  final beat of the burst
- burst_done  output  1  one-cycle pulse, coincident with the last result

## Operation

- FSM states: IDLE, STREAM, DRAIN.
- **IDLE**
  - If any req bit is high, pick the winner by round-robin, starting at pointer ptr.
  - Register the one-hot gnt and clear the beat counter, then move to STREAM.
  - If no req bit is high, stay in IDLE.
- **STREAM**
  - A beat is accepted when in_valid[g] & in_ready[g] is high.
  - relu_in_valid = accepted, combinationally in the same cycle. relu_in_data = the granted requester's slice, combinationally.
  - Each accepted beat pushes a tag {id, idx, last, vld=1} into a RELU_LAT-deep shift register.
  - Counter increments per accepted beat. On acceptance of beat BURST_LEN-1, set last=1 in its tag and move to DRAIN.
  - Stalls (in_valid low) are allowed at any point; the counter holds.
- **DRAIN**
  - gnt is held and in_ready = 0.
  - Stay for RELU_LAT cycles, until the last tag leaves the pipe.
  - Then clear gnt, set ptr = (winner+1) mod NUM_REQ, and move to IDLE.
- **Outputs**
  - out_data = relu_out_data.
  - out_valid = relu_out_valid & tag_vld. A ReLU valid with no matching tag is ignored.
  - out_id, out_idx and out_last come from the tag pipe head.
  - burst_done = out_valid & out_last.
- **Requester rules**
  - req is sampled only in IDLE. Deasserting req mid-burst has no effect; the burst must complete.
  - A requester may hold req high continuously; it is re-granted only after every other active requester has been served once.
- **Reset (rst low)**
  - Asynchronous clear of FSM to IDLE, ptr=0, counter, tag pipe, gnt=0, in_ready=0, relu_in_valid=0.
  - All out_* = 0 and burst_done = 0.
  - A burst in flight is discarded; no burst_done is issued.

## Timing

- Arbitration: req high in IDLE at edge N -> gnt/in_ready high after edge N, in the cycle following edge N.
- First beat is accepted in the first STREAM cycle if in_valid is high.
- Result for a beat accepted at edge K appears with out_valid high after edge K+RELU_LAT.
- Minimum burst occupancy: 1 (IDLE) + BURST_LEN + RELU_LAT cycles.
- Back-to-back bursts with no stalls: one result gap of 1+RELU_LAT cycles between bursts.
- At most one beat per cycle into the ReLU; no output backpressure, so downstream must accept every out_valid.

## Test plan

- **Single burst:** NUM_REQ=2, BURST_LEN=4, RELU_LAT=1, only req[0]; beats -3, 5, 0, -1 -> out_data 0, 5, 0, 0 on consecutive cycles. out_id=0, out_idx 0..3, out_last and burst_done only on idx 3. gnt[0] drops one cycle after the last result.
- **Contention:** req=2'b11 from reset -> requester 0 served first, then requester 1. With both held high for 4 bursts, the grant order is 0, 1, 0, 1.
- **Stalls:** requester 1 drops in_valid for 3 cycles after beat 1 -> no ReLU input during the gap, indices stay contiguous 0..3, burst_done arrives 3 cycles later than unstalled.
- **Extremes:** beats 0x8000, 0x7FFF, 0x0001, 0xFFFF -> 0x0000, 0x7FFF, 0x0001, 0x0000.
- **Reset mid-burst:** rst low after beat 2 of requester 0 -> all outputs 0 immediately, no burst_done. After release with req[1] only, requester 1 is granted and completes normally.
- **Late requester:** req[0] deasserted during its STREAM -> burst still completes all BURST_LEN beats, then returns to IDLE with ptr=1.
